// File: rtl/mux_nway_stream_pkg.sv
// Shared constants and helpers for the N-way registered stream multiplexer.
// Mode selectors, output-stage state encoding and small index arithmetic.
package mux_nway_stream_pkg;

    localparam int MUX_MODE_SEL = 0;
    localparam int MUX_MODE_RR  = 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // Smallest r with 2**r >= n; used to derive channel-index widths.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // (base + off) mod n, valid while base < n and off <= n.
    function automatic int wrap_idx(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/mux_nway_stream_if.sv
// Handshake bundle between NCH producers, the multiplexer and one consumer.
// A word moves on any edge where its valid and ready are both high; valid never waits on ready.
interface mux_nway_stream_if
    import mux_nway_stream_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int SELW  = clog2(NCH)
);

    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [SELW-1:0]      sel;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [SELW-1:0]      out_ch;

    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );

    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );

endinterface

// File: rtl/mux_nway_stream_rr_arbiter.sv
// Rotating-priority encoder: grants the first requester at or after ptr, wrapping at NCH.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter
    import mux_nway_stream_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int SELW = clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] gnt,
    output logic            gnt_vld
);

    // Scan from the farthest offset down so the closest requester to ptr wins last.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (wrap_idx(int'(ptr), k, NCH) < NCH) begin
                if (req[wrap_idx(int'(ptr), k, NCH)]) begin
                    gnt     = SELW'(wrap_idx(int'(ptr), k, NCH));
                    gnt_vld = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mux_nway_stream.sv
// N-channel stream multiplexer with one registered output stage and back-pressure.
// Channel choice comes from sel (MODE 0) or a round-robin pointer (MODE 1).
module mux_nway_stream
    import mux_nway_stream_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int SELW  = clog2(NCH),
    parameter int MODE  = MUX_MODE_SEL
) (
    input  logic                    clk,
    input  logic                    rst,
    mux_nway_stream_if.slave        bus,
    output out_state_e              state_dbg,
    output logic [SELW-1:0]         ptr_dbg
);

    out_state_e       state;
    out_state_e       state_next;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] word;
    logic [SELW-1:0]  ch_q;
    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  gnt;
    logic             gnt_vld;
    logic             load_en;
    logic             take;

    generate
        if (MODE == MUX_MODE_RR) begin : g_rr
            rr_arbiter #(
                .NCH  (NCH),
                .SELW (SELW)
            ) u_arb (
                .req     (bus.in_valid),
                .ptr     (ptr),
                .gnt     (gnt),
                .gnt_vld (gnt_vld)
            );
        end else begin : g_sel
            // An out-of-range sel simply matches no channel.
            always_comb begin
                gnt     = bus.sel;
                gnt_vld = 1'b0;
                for (int i = 0; i < NCH; i++) begin
                    if (bus.sel == SELW'(i) && bus.in_valid[i]) begin
                        gnt_vld = 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign load_en = (state == ST_EMPTY) || bus.out_ready;
    assign take    = !rst && load_en && gnt_vld;

    // Ready and data steering decode the grant only, never in_data.
    always_comb begin
        bus.in_ready = '0;
        word         = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt == SELW'(i)) begin
                bus.in_ready[i] = take;
                word            = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: if (take) state_next = ST_FULL;
            ST_FULL:  if (bus.out_ready && !take) state_next = ST_EMPTY;
            default:  state_next = ST_EMPTY;
        endcase
    end

    // Payload is only rewritten on a load, so a drain leaves the last word visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            ch_q   <= '0;
        end else if (take) begin
            data_q <= word;
            ch_q   <= gnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (MODE == MUX_MODE_RR && take) begin
            ptr <= SELW'(wrap_idx(int'(gnt), 1, NCH));
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;
    assign bus.out_valid = (state == ST_FULL);
    assign state_dbg     = state;
    assign ptr_dbg       = ptr;

endmodule

// File: doc/mux_nway_stream.md
# mux_nway_stream

Parametrised N-channel, WIDTH-bit stream multiplexer. It is the registered, handshaked successor of the 2:1 16-bit datapath mux. It selects one of NCH valid/ready input channels, either by an explicit select input or by round-robin arbitration. The winning word is captured into a single output register stage. It sits between multiple datapath producers and a single consumer (ALU operand bus, display or UART path), with back-pressure.

## Interface
- WIDTH, 16: data word width in bits (≥1).
- NCH, 4: number of input channels (2..16).
- SELW, 2: select/channel-index width, must equal ceil(log2(NCH)).
- MODE, 0: 0 = explicit select via `sel`; 1 = round-robin arbitration (`sel` ignored).
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready (combinational).
- sel  input  SELW  channel select; used in MODE 0 only.
- out_data  output  WIDTH  registered output word.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word this cycle.
- out_ch  output  SELW  index of the channel that produced out_data.

## Operation
- Output stage has two states: EMPTY (out_valid=0) and FULL (out_valid=1).
- load_en = !out_valid || out_ready. The register can accept a new word when it is empty or is being drained in the same cycle.
- Grant in MODE 0:
  - gnt = sel, if sel < NCH and in_valid[sel].
  - Otherwise there is no grant.
- Grant in MODE 1:
  - gnt = first i with in_valid[i], scanning ptr, ptr+1, …, NCH-1, 0, …, ptr-1.
  - No grant if no channel is valid.
- in_ready[i] = load_en && grant exists && gnt==i. At most one in_ready bit is high per cycle.
- Transfer into the register happens when in_valid[gnt] && in_ready[gnt]:
  - out_data ← word of channel gnt.
  - out_ch ← gnt.
  - out_valid ← 1.
- Drain without a new load (out_valid && out_ready, no grant) → out_valid ← 0. out_data and out_ch hold their last values.
- Simultaneous drain and load → out_valid stays 1 and the new word replaces the old one. This gives one word per cycle throughput.
- FULL && !out_ready → out_data, out_ch and out_valid are held stable, and all in_ready are 0.
- Round-robin pointer ptr (SELW bits, MODE 1 only):
  - On each accepted input transfer, ptr ← gnt+1.
  - Wrap from NCH-1 to 0, including when NCH is not a power of 2.
  - ptr does not change when there is no transfer.
- sel ≥ NCH in MODE 0 is not an error. It simply produces no grant.

## Timing
- Reset values, applied asynchronously: out_valid=0, out_data=0, out_ch=0, ptr=0. in_ready=0 while rst is high.
- Latency: an input accepted at edge k appears as out_valid=1 with that data after edge k.
- in_ready depends combinationally on in_valid, sel, out_valid, out_ready and ptr. It has no combinational path from in_data.
- Reset asserted mid-operation: any word held in the output register is discarded. No partial output occurs, and out_valid falls immediately.
- The first edge after reset release may already accept a word.

## Structure
- Shared Verilog header file (`` `include ``):
  - mode constants MUX_MODE_SEL=0 and MUX_MODE_RR=1;
  - a clog2 helper function for deriving SELW.
- One natural sub-module, rr_arbiter (parameter NCH):
  - inputs: req[NCH], ptr;
  - outputs: gnt index and gnt_vld;
  - purely combinational rotate-priority-encode.
- The top level holds the ptr register, the output register and the load_en logic.
- MODE 0 bypasses rr_arbiter.

## Test plan
- Reset: assert rst asynchronously mid-cycle while FULL with out_data=16'hBEEF → out_valid, out_data and out_ch become 0 immediately, and in_ready=0 until release.
- MODE 0 select: WIDTH=16, NCH=4, ch2=16'h1234 valid, sel=2, out_ready=1 → in_ready=4'b0100. The next cycle gives out_data=16'h1234 and out_ch=2. With sel=5 (NCH=5, SELW=3), in_ready=0 and no output appears.
- Back-pressure: out_ready=0 for 3 cycles after a word is loaded → out_data stays stable, in_ready=0 throughout. When out_ready=1 again, a new word loads in the same cycle (one word per cycle, no bubble).
- MODE 1 fairness: all 4 channels valid continuously, out_ready=1 → out_ch sequence is 0,1,2,3,0,1 and in_ready rotates one-hot.
- MODE 1 wrap and sparse requests: NCH=3, only channels 0 and 2 valid, ptr=0 after reset → grants go 0,2,0,2. Check that ptr wraps from 2+1 to 0, not 3.
- Drain-only: FULL, out_ready=1, no valid inputs → out_valid drops after one edge, and out_data retains its last value.
